phy_rx_serial_to_parallel: RTL and testbench

//  Receive-side lane deserializer: consumes one serial lane (serial_o0/serial_o1) driven by phy_tx.

---
 rtl/phy_pkg.sv | 24 ++
 rtl/rx_com_aligner.sv | 60 ++++++
 rtl/phy_rx_serial_to_parallel.sv | 126 ++++++++++++
 tb/tb_phy_rx_serial_to_parallel.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : phy_pkg
//  Purpose : Shared PHY constants. Holds the line symbols, the default symbol
//            width and the receive-lane state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package phy_pkg;

    // Default bits per symbol
    localparam int c_byte_w_def = 8;

    // Line symbols
    localparam logic [7:0] c_com_sym = 8'hBC;   // comma / alignment
    localparam logic [7:0] c_idl_sym = 8'h7C;   // idle filler

    // Receive lane state encoding
    localparam logic [1:0] c_rx_hunt   = 2'd0;
    localparam logic [1:0] c_rx_align  = 2'd1;
    localparam logic [1:0] c_rx_active = 2'd2;

endpackage : phy_pkg
`default_nettype wire

// File: rtl/rx_com_aligner.sv
`default_nettype none
// ============================================================================
//  Module  : rx_com_aligner
//  Purpose : Serial shift register, symbol bit counter and comma compare for
//            one receive lane. The parent FSM decides what the results mean.
//  Ports   : clk        - bit-rate clock
//            reset      - synchronous, active-high
//            serial_in  - serial lane data, MSB first
//            restart    - zero the bit counter (comma found while hunting)
//            nxt        - shift register contents including this cycle's bit
//            boundary   - this cycle completes a symbol
//            is_com     - nxt equals the comma symbol
//  Rev     : 1.0  initial release
// ============================================================================
module rx_com_aligner
    import phy_pkg::*;
#(
    parameter int               BYTE_W = c_byte_w_def,
    parameter logic [BYTE_W-1:0] COM   = BYTE_W'(c_com_sym)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              restart,
    output logic [BYTE_W-1:0] nxt,
    output logic              boundary,
    output logic              is_com
);

    localparam int               c_cnt_w = (BYTE_W > 2) ? $clog2(BYTE_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BYTE_W - 1);

    logic [BYTE_W-1:0]  r_sr;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [BYTE_W-1:0]  w_nxt;

    // Value the shift register takes this edge; all decisions use it so a
    // symbol is recognised in the same cycle its last bit arrives.
    assign w_nxt    = {r_sr[BYTE_W-2:0], serial_in};
    assign nxt      = w_nxt;
    assign is_com   = (w_nxt == COM);
    assign boundary = (r_bit_cnt == c_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_sr <= w_nxt;
            // A comma found while hunting ends a symbol, so the next bit is bit 0
            if (restart || (r_bit_cnt == c_last)) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule : rx_com_aligner
`default_nettype wire

// File: rtl/phy_rx_serial_to_parallel.sv
`default_nettype none
// ============================================================================
//  Module  : phy_rx_serial_to_parallel
//  Purpose : Receive-side lane deserializer. Hunts for the comma bit by bit,
//            qualifies the byte boundary after LOCK_COMS consecutive aligned
//            commas, then emits one byte per BYTE_W bit clocks.
//  Ports   : clk         - bit-rate clock
//            reset       - synchronous, active-high
//            serial_in   - serial lane data, MSB first
//            data_out    - last complete aligned byte, held between boundaries
//            valid_out   - data_out holds a non-comma byte received when active
//            byte_strobe - one-cycle pulse whenever data_out/valid_out update
//            active      - lane qualified
//  Rev     : 1.0  initial release
// ============================================================================
module phy_rx_serial_to_parallel
    import phy_pkg::*;
#(
    parameter int                BYTE_W    = c_byte_w_def,
    parameter logic [BYTE_W-1:0] COM       = BYTE_W'(c_com_sym),
    parameter int                LOCK_COMS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              byte_strobe,
    output logic              active
);

    localparam logic [3:0] c_lock_coms  = 4'(LOCK_COMS);
    localparam bit         c_single_com = (LOCK_COMS == 1);

    logic [1:0]        r_state;
    logic [3:0]        r_com_cnt;
    logic [BYTE_W-1:0] r_data;
    logic              r_valid;
    logic              r_strobe;
    logic              r_active;

    logic [BYTE_W-1:0] w_nxt;
    logic              w_boundary;
    logic              w_is_com;
    logic              w_restart;

    // Any comma seen while hunting defines the byte phase from here on
    assign w_restart = (r_state == c_rx_hunt) && w_is_com;

    rx_com_aligner #(
        .BYTE_W (BYTE_W),
        .COM    (COM)
    ) u_aligner (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .restart   (w_restart),
        .nxt       (w_nxt),
        .boundary  (w_boundary),
        .is_com    (w_is_com)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_rx_hunt;
            r_com_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_strobe  <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                c_rx_hunt: begin
                    if (w_is_com) begin
                        r_com_cnt <= 4'd1;
                        if (c_single_com) begin
                            r_state  <= c_rx_active;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= c_rx_align;
                        end
                    end
                end

                c_rx_align: begin
                    if (w_boundary) begin
                        if (w_is_com) begin
                            r_com_cnt <= r_com_cnt + 4'd1;
                            if ((r_com_cnt + 4'd1) == c_lock_coms) begin
                                r_state  <= c_rx_active;
                                r_active <= 1'b1;
                            end
                        end else begin
                            // Broken preamble: forget the phase and search again
                            r_state   <= c_rx_hunt;
                            r_com_cnt <= '0;
                        end
                    end
                end

                c_rx_active: begin
                    // No loss-of-lock detection: only reset leaves this state
                    if (w_boundary) begin
                        r_data   <= w_nxt;
                        r_valid  <= !w_is_com;
                        r_strobe <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= c_rx_hunt;
                    r_com_cnt <= '0;
                    r_active  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active      = r_active;

endmodule : phy_rx_serial_to_parallel
`default_nettype wire

// File: tb/tb_phy_rx_serial_to_parallel.sv
`default_nettype none
// ============================================================================
//  Module  : tb_phy_rx_serial_to_parallel
//  Purpose : Self-checking bench for the lane deserializer. Directed lock,
//            data, misalignment, broken-preamble and reset scenarios plus
//            randomized streams compared against a behavioural model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_phy_rx_serial_to_parallel;

    localparam logic [7:0] c_com  = 8'hBC;
    localparam int         c_lock = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int n_checks = 0;
    int n_pass   = 0;

    phy_rx_serial_to_parallel #(
        .BYTE_W    (8),
        .COM       (8'hBC),
        .LOCK_COMS (c_lock)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: the lane is described by a mode, the cycle at
    // which the byte phase was anchored and the number of aligned commas.
    // A byte boundary is any cycle a whole multiple of 8 after the anchor.
    // ------------------------------------------------------------------
    int         m_mode;     // 0 searching, 1 qualifying, 2 locked
    int         m_cyc;
    int         m_anchor;
    int         m_coms;
    logic [7:0] m_win;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_strobe;
    logic       m_active;

    task automatic model_step(input logic b, input logic rst);
        if (rst) begin
            m_mode = 0; m_cyc = 0; m_anchor = 0; m_coms = 0;
            m_win = 8'h00; m_data = 8'h00;
            m_valid = 1'b0; m_strobe = 1'b0; m_active = 1'b0;
        end else begin
            m_win    = {m_win[6:0], b};
            m_cyc    = m_cyc + 1;
            m_strobe = 1'b0;
            case (m_mode)
                0: if (m_win == c_com) begin
                    m_anchor = m_cyc;
                    m_coms   = 1;
                    m_mode   = (c_lock == 1) ? 2 : 1;
                end
                1: if (((m_cyc - m_anchor) % 8) == 0) begin
                    if (m_win == c_com) begin
                        m_coms = m_coms + 1;
                        if (m_coms == c_lock) m_mode = 2;
                    end else begin
                        m_mode = 0;
                        m_coms = 0;
                    end
                end
                default: if (((m_cyc - m_anchor) % 8) == 0) begin
                    m_data   = m_win;
                    m_valid  = (m_win != c_com);
                    m_strobe = 1'b1;
                end
            endcase
            m_active = (m_mode == 2);
        end
    endtask

    // Drive one bit, let the DUT sample it, step the model alongside
    task automatic drive_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
        model_step(b, reset);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) drive_bit(v[i]);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) drive_bit(v[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) drive_bit(1'($urandom % 2));
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'(i % 2));
            n_checks++;
            if ({data_out, valid_out, byte_strobe, active} !== 11'h000)
                $display("FAIL reset_outputs cycle %0d: got data=%h v=%b s=%b a=%b, want all 0",
                         i, data_out, valid_out, byte_strobe, active);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_lock_and_data();
        logic [7:0] exp_bytes [4];
        int         strobe_at [$];
        logic [7:0] got_data  [$];
        logic       got_valid [$];
        logic [7:0] cur;
        exp_bytes = '{8'hF4, 8'hFF, 8'hEF, 8'h7F};
        repeat (3) send_byte(c_com);
        send_bits(c_com, 7);
        n_checks++;
        if (active !== 1'b0) $display("FAIL lock_early: active=%b want 0", active);
        else n_pass++;
        drive_bit(c_com[0]);
        n_checks++;
        if (active !== 1'b1 || valid_out !== 1'b0 || byte_strobe !== 1'b0)
            $display("FAIL lock_edge: active=%b valid=%b strobe=%b want 1 0 0",
                     active, valid_out, byte_strobe);
        else n_pass++;
        for (int k = 0; k < 32; k++) begin
            cur = exp_bytes[k / 8];
            drive_bit(cur[7 - (k % 8)]);
            if (byte_strobe === 1'b1) begin
                strobe_at.push_back(k);
                got_data.push_back(data_out);
                got_valid.push_back(valid_out);
            end
        end
        n_checks++;
        if (strobe_at.size() != 4) $display("FAIL data_strobe_count: got %0d want 4", strobe_at.size());
        else n_pass++;
        for (int j = 0; j < strobe_at.size() && j < 4; j++) begin
            n_checks++;
            if (strobe_at[j] != 8 * j + 7 || got_data[j] !== exp_bytes[j] || got_valid[j] !== 1'b1)
                $display("FAIL data_byte%0d: bit=%0d data=%h valid=%b want bit=%0d data=%h valid=1",
                         j, strobe_at[j], got_data[j], got_valid[j], 8 * j + 7, exp_bytes[j]);
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        repeat (3) send_byte(c_com);
        send_bits(c_com, 7);
        n_checks++;
        if (active !== 1'b0) $display("FAIL misalign_early: active=%b want 0", active);
        else n_pass++;
        drive_bit(c_com[0]);
        n_checks++;
        if (active !== 1'b1) $display("FAIL misalign_lock: active=%b want 1", active);
        else n_pass++;
        send_bits(8'h8C, 7);
        n_checks++;
        if (byte_strobe !== 1'b0) $display("FAIL misalign_midbyte: strobe=%b want 0", byte_strobe);
        else n_pass++;
        drive_bit(1'b0);
        n_checks++;
        if (byte_strobe !== 1'b1 || data_out !== 8'h8C || valid_out !== 1'b1)
            $display("FAIL misalign_data: strobe=%b data=%h valid=%b want 1 8c 1",
                     byte_strobe, data_out, valid_out);
        else n_pass++;
    endtask

    task automatic test_broken_preamble();
        do_reset();
        send_byte(c_com); send_byte(c_com); send_byte(8'h55);
        n_checks++;
        if (active !== 1'b0) $display("FAIL broken_after55: active=%b want 0", active);
        else n_pass++;
        send_byte(c_com); send_byte(c_com);
        n_checks++;
        if (active !== 1'b0) $display("FAIL broken_two_more: active=%b want 0", active);
        else n_pass++;
        send_byte(c_com);
        send_bits(c_com, 7);
        n_checks++;
        if (active !== 1'b0) $display("FAIL broken_early: active=%b want 0", active);
        else n_pass++;
        drive_bit(c_com[0]);
        n_checks++;
        if (active !== 1'b1) $display("FAIL broken_relock: active=%b want 1", active);
        else n_pass++;
    endtask

    task automatic test_com_and_reset();
        logic [7:0] seq [3];
        logic       vexp [3];
        seq  = '{8'hD4, 8'hBC, 8'hDD};
        vexp = '{1'b1, 1'b0, 1'b1};
        do_reset();
        repeat (4) send_byte(c_com);
        for (int j = 0; j < 3; j++) begin
            send_byte(seq[j]);
            n_checks++;
            if (byte_strobe !== 1'b1 || data_out !== seq[j] || valid_out !== vexp[j])
                $display("FAIL com_in_data%0d: strobe=%b data=%h valid=%b want 1 %h %b",
                         j, byte_strobe, data_out, valid_out, seq[j], vexp[j]);
            else n_pass++;
        end
        send_bits(8'hA5, 3);
        reset = 1'b1;
        drive_bit(1'b0);
        reset = 1'b0;
        n_checks++;
        if ({data_out, valid_out, byte_strobe, active} !== 11'h000)
            $display("FAIL midop_reset: data=%h v=%b s=%b a=%b want all 0",
                     data_out, valid_out, byte_strobe, active);
        else n_pass++;
        repeat (3) send_byte(c_com);
        n_checks++;
        if (active !== 1'b0) $display("FAIL relock_early: active=%b want 0", active);
        else n_pass++;
        send_byte(c_com);
        n_checks++;
        if (active !== 1'b1) $display("FAIL relock: active=%b want 1", active);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         nbits;
        int         nfail_here;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            nfail_here = 0;
            nbits = $urandom_range(0, 20);
            for (int k = 0; k < nbits + 32 + 160; k++) begin
                if (k < nbits)            drive_bit(1'($urandom % 2));
                else if (k < nbits + 32)  drive_bit(c_com[7 - ((k - nbits) % 8)]);
                else begin
                    if (((k - nbits) % 8) == 0) b = 8'($urandom);
                    // Occasional commas in the data stream
                    if (((k - nbits) % 8) == 0 && ($urandom % 6) == 0) b = c_com;
                    drive_bit(b[7 - ((k - nbits) % 8)]);
                end
                n_checks++;
                if (data_out !== m_data || valid_out !== m_valid ||
                    byte_strobe !== m_strobe || active !== m_active) begin
                    if (nfail_here < 5)
                        $display("FAIL random_it%0d_bit%0d: got d=%h v=%b s=%b a=%b want d=%h v=%b s=%b a=%b",
                                 it, k, data_out, valid_out, byte_strobe, active,
                                 m_data, m_valid, m_strobe, m_active);
                    nfail_here++;
                end else n_pass++;
            end
        end
    endtask

    initial begin
        model_step(1'b0, 1'b1);
        test_reset();
        test_clean_lock_and_data();
        test_misaligned();
        test_broken_preamble();
        test_com_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_phy_rx_serial_to_parallel
`default_nettype wire
